fft_chan_sched: RTL
===================

// Module: fft_chan_sched
// PURPOSE
//  Round-robin scheduler that shares one FFT engine (start/done, 256-pt, peak-bin outputs)
//  between NCH ADC input buffers. Grants one full buffer at a time and drives the channel
//  select for the engine's input-read mux. Blocks new rounds while the display reads the
//  output RAM, guards each round with a timeout, and publishes per-round results.
// PARAMETERS
//  NCH        2       number of requesting input channels (2..8)
//  CW         1       width of chan_sel/res_chan, = clog2(NCH), min 1
//  ADDR_WIDTH 8       FFT bin address width (peak indices)
//  TMO_W      16      timeout counter width
//  TIMEOUT    40000   max cycles from fft_start to fft_done before abort
// PORTS
//  clk        in   1           system clock, same as FFT engine
//  rst        in   1           synchronous reset, active-high
//  enable     in   1           1 = new grants allowed
//  frame_req  in   NCH         level, channel i input buffer full
//  frame_ack  out  NCH         1-cycle pulse, release channel i buffer
//  chan_sel   out  CW          granted channel, drives engine input mux
//  fft_start  out  1           1-cycle start pulse to engine
//  fft_done   in   1           1-cycle done pulse from engine
//  max1_in    in   ADDR_WIDTH  engine main-peak bin, valid with fft_done
//  max2_in    in   ADDR_WIDTH  engine second-peak bin, valid with fft_done
//  out_busy   in   1           level, display is reading the output RAM
//  busy       out  1           1 whenever state != IDLE
//  res_valid  out  1           1-cycle pulse, result registers updated
//  res_chan   out  CW          channel of last good result
//  res_max1   out  ADDR_WIDTH  main-peak bin of last good result
//  res_max2   out  ADDR_WIDTH  second-peak bin of last good result
//  tmo_err    out  1           sticky, set on any timeout, cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; timer 0.
//  FSM states IDLE, START, RUN, DONE. All outputs registered.
//  IDLE: grant when enable & |frame_req & ~out_busy. Winner = first set frame_req bit
//    searching up from ptr, wrapping mod NCH. Latch chan_sel = winner; ptr <= winner+1
//    (wraps NCH-1 -> 0); go to START. Otherwise stay.
//  START (1 cycle): fft_start = 1; timer <= 0; go to RUN.
//  RUN: chan_sel held constant. fft_start = 0. Timer increments each cycle.
//    fft_done=1 -> latch max1_in/max2_in/chan_sel into result shadow; go to DONE.
//    else timer == TIMEOUT-1 -> tmo_err <= 1; frame_ack[chan_sel] pulse; no res_valid;
//    go to IDLE (frame dropped). If fft_done and timeout coincide, fft_done wins.
//  DONE (1 cycle): res_valid = 1, res_chan/res_max1/res_max2 updated in same cycle;
//    frame_ack[chan_sel] = 1; go to IDLE.
//  Latency: req sampled in IDLE at edge t -> fft_start high in cycle t+1;
//    fft_done at edge d -> res_valid and frame_ack high in cycle d+1.
//  Back-to-back: next grant evaluated in the IDLE cycle after DONE, so at least one
//    idle cycle separates rounds; frame_req of the acked channel is ignored for that
//    one IDLE cycle (buffer owner needs one cycle to drop the request).
//  fft_done outside RUN: ignored, no state change.
//  out_busy checked only at grant; a rise during RUN does not stall the round.
//  enable low mid-round: current round completes normally; no further grants.
//  frame_req dropping during RUN: round completes, frame_ack still issued.
//  res_* hold last good values until next res_valid; at most one frame_ack bit is set per cycle.
//  rst mid-round: immediate return to IDLE, no ack/res_valid issued, tmo_err cleared.
//  Timer: TMO_W bits, must not wrap; TIMEOUT < 2**TMO_W.
// TESTING
//  1 frame_req=01, done 300 cyc after start, max1=0x12,max2=0x30 -> start at t+1,
//    res_valid once, res_chan=0, res_max1=0x12, res_max2=0x30, frame_ack=01 pulse.
//  2 frame_req=11 held, 4 rounds -> grant order 0,1,0,1; exactly one ack per round.
//  3 out_busy=1 with frame_req=01 for 100 cyc -> no fft_start; drop out_busy ->
//    fft_start on next cycle after sampling.
//  4 TIMEOUT=50, no fft_done -> tmo_err=1 at cycle 50 of RUN, frame_ack pulse,
//    res_valid stays 0, res_* unchanged; next round proceeds normally.
//  5 fft_done on the exact timeout cycle -> res_valid=1, tmo_err stays 0.
//  6 rst pulse during RUN then stray fft_done -> outputs 0, state IDLE, done ignored.

Source files
------------

// File: rtl/fft_chan_sched_if.sv
// Bundle of the scheduler's channel, FFT-engine and result signals.
// The master modport is the scheduler; the slave modport is everything around it.
interface fft_chan_sched_if #(
  parameter int NCH        = 2,
  parameter int CW         = 1,
  parameter int ADDR_WIDTH = 8
);
  logic                  enable;
  logic [NCH-1:0]        frame_req;
  logic [NCH-1:0]        frame_ack;
  logic [CW-1:0]         chan_sel;
  logic                  fft_start;
  logic                  fft_done;
  logic [ADDR_WIDTH-1:0] max1_in;
  logic [ADDR_WIDTH-1:0] max2_in;
  logic                  out_busy;
  logic                  busy;
  logic                  res_valid;
  logic [CW-1:0]         res_chan;
  logic [ADDR_WIDTH-1:0] res_max1;
  logic [ADDR_WIDTH-1:0] res_max2;
  logic                  tmo_err;

  modport master (
    input  enable, frame_req, fft_done, max1_in, max2_in, out_busy,
    output frame_ack, chan_sel, fft_start, busy, res_valid, res_chan,
           res_max1, res_max2, tmo_err
  );

  modport slave (
    output enable, frame_req, fft_done, max1_in, max2_in, out_busy,
    input  frame_ack, chan_sel, fft_start, busy, res_valid, res_chan,
           res_max1, res_max2, tmo_err
  );
endinterface

// File: rtl/fft_chan_sched.sv
// Round-robin arbiter sharing one FFT engine between NCH input buffers, with a
// per-round timeout and registered result publication.
module fft_chan_sched #(
  parameter int NCH        = 2,
  parameter int CW         = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int TMO_W      = 16,
  parameter int TIMEOUT    = 40000
) (
  input logic              clk,
  input logic              rst,
  fft_chan_sched_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    ptr;
  logic [CW-1:0]    winner;
  logic [TMO_W-1:0] timer;
  logic [NCH-1:0]   ack_mask;
  logic [NCH-1:0]   req_eff;
  logic [NCH-1:0]   sel_onehot;
  logic             grant;
  logic             done_hit;
  logic             tmo_hit;
  int               idx;

  assign sel_onehot = NCH'(1) << bus.chan_sel;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    winner    = '0;
    idx       = 0;
    // The channel just released is hidden for one IDLE cycle so its owner can drop the request.
    req_eff   = bus.frame_req & ~ack_mask;
    case (state)
      IDLE: begin
        if (bus.enable && !bus.out_busy && (|req_eff)) begin
          grant     = 1'b1;
          state_nxt = START;
          // Scanning downwards lets the lowest offset from ptr be the last, winning, hit.
          for (int i = NCH - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (req_eff[idx]) winner = CW'(idx);
          end
        end
      end
      START: state_nxt = RUN;
      RUN: begin
        if (bus.fft_done) begin
          done_hit  = 1'b1;
          state_nxt = DONE;
        end else if (timer == TMO_W'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      timer         <= '0;
      ack_mask      <= '0;
      bus.chan_sel  <= '0;
      bus.fft_start <= 1'b0;
      bus.frame_ack <= '0;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_chan  <= '0;
      bus.res_max1  <= '0;
      bus.res_max2  <= '0;
      bus.tmo_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.busy      <= (state_nxt != IDLE);
      bus.fft_start <= grant;
      bus.res_valid <= done_hit;
      bus.frame_ack <= (done_hit || tmo_hit) ? sel_onehot : '0;
      ack_mask      <= ((state == DONE) || tmo_hit) ? sel_onehot : '0;

      if (grant) begin
        bus.chan_sel <= winner;
        ptr          <= (winner == CW'(NCH - 1)) ? '0 : winner + 1'b1;
      end

      if (state == START)    timer <= '0;
      else if (state == RUN) timer <= timer + 1'b1;

      if (done_hit) begin
        bus.res_chan <= bus.chan_sel;
        bus.res_max1 <= bus.max1_in;
        bus.res_max2 <= bus.max2_in;
      end

      if (tmo_hit) bus.tmo_err <= 1'b1;
    end
  end

endmodule
